// File: rtl/pattern_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sort_sequencer
// Purpose  : Shares one best-of-5 pattern sorter across NGRP candidate groups.
//            On start it sweeps grp_sel twice: pass 1 picks the best pattern,
//            pass 2 picks the best pattern whose combined key lies outside a
//            +/-BUSY_SPAN window around the first. Results are published with
//            a one-cycle done pulse and held until the next frame completes.
// Ports    : clock, reset_n (async, active-low)
//            start, abort           - frame control
//            grp_sel                - group presented to the shared sorter
//            sort_pat/key/carry     - sorter result for grp_sel (same cycle)
//            busy, done             - status
//            first_*/second_*       - selected patterns, keys {grp,key}, carries
// Revision : 1.0 - initial release
// ============================================================================
module pattern_sort_sequencer #(
  parameter int NGRP      = 7,
  parameter int GRPB      = 3,
  parameter int PATB      = 11,
  parameter int KEYB      = 8,
  parameter int CARB      = 12,
  parameter int BUSY_SPAN = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [GRPB-1:0]      grp_sel,
  input  logic [PATB-1:0]      sort_pat,
  input  logic [KEYB-1:0]      sort_key,
  input  logic [CARB-1:0]      sort_carry,
  output logic                 busy,
  output logic                 done,
  output logic                 first_vld,
  output logic                 second_vld,
  output logic [PATB-1:0]      first_pat,
  output logic [PATB-1:0]      second_pat,
  output logic [GRPB+KEYB-1:0] first_key,
  output logic [GRPB+KEYB-1:0] second_key,
  output logic [CARB-1:0]      first_carry,
  output logic [CARB-1:0]      second_carry
);

  localparam int                 c_CKB  = GRPB + KEYB;
  localparam logic [GRPB-1:0]    c_LAST = GRPB'(NGRP - 1);
  localparam logic [c_CKB-1:0]   c_SPAN = c_CKB'(BUSY_SPAN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;

  // Running selections for the frame in progress.
  logic               r_first_vld;
  logic [PATB-1:0]    r_first_pat;
  logic [c_CKB-1:0]   r_first_key;
  logic [CARB-1:0]    r_first_carry;
  logic               r_second_vld;
  logic [PATB-1:0]    r_second_pat;
  logic [c_CKB-1:0]   r_second_key;
  logic [CARB-1:0]    r_second_carry;

  logic [PATB-2:0]    w_cand_sk;
  logic [c_CKB-1:0]   w_cand_key;
  logic [c_CKB-1:0]   w_dist;
  logic               w_take_first;
  logic               w_take_second;
  logic               w_last;

  // Bit 0 of the pattern id is bend direction and takes no part in ranking.
  // Running registers are cleared at start, so an empty slot ranks as sk=0 and
  // "strictly greater" alone also covers the first valid candidate.
  assign w_cand_sk     = sort_pat[PATB-1:1];
  assign w_cand_key    = {grp_sel, sort_key};
  assign w_dist        = (w_cand_key >= r_first_key) ? (w_cand_key - r_first_key)
                                                     : (r_first_key - w_cand_key);
  assign w_take_first  = (w_cand_sk != '0) && (w_cand_sk > r_first_pat[PATB-1:1]);
  assign w_take_second = (w_cand_sk != '0) && (w_dist > c_SPAN) &&
                         (w_cand_sk > r_second_pat[PATB-1:1]);
  assign w_last        = (grp_sel == c_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      grp_sel        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      r_first_vld    <= 1'b0;
      r_first_pat    <= '0;
      r_first_key    <= '0;
      r_first_carry  <= '0;
      r_second_vld   <= 1'b0;
      r_second_pat   <= '0;
      r_second_key   <= '0;
      r_second_carry <= '0;
      first_vld      <= 1'b0;
      first_pat      <= '0;
      first_key      <= '0;
      first_carry    <= '0;
      second_vld     <= 1'b0;
      second_pat     <= '0;
      second_key     <= '0;
      second_carry   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        grp_sel <= '0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_first_vld    <= 1'b0;
              r_first_pat    <= '0;
              r_first_key    <= '0;
              r_first_carry  <= '0;
              r_second_vld   <= 1'b0;
              r_second_pat   <= '0;
              r_second_key   <= '0;
              r_second_carry <= '0;
              busy           <= 1'b1;
              r_state        <= PASS1;
            end
          end

          PASS1: begin
            if (w_take_first) begin
              r_first_vld   <= 1'b1;
              r_first_pat   <= sort_pat;
              r_first_key   <= w_cand_key;
              r_first_carry <= sort_carry;
            end
            if (w_last) begin
              grp_sel <= '0;
              if (r_first_vld || w_take_first) begin
                r_state <= PASS2;
              end else begin
                // Nothing found: publish an empty result straight away.
                r_state      <= DONE;
                done         <= 1'b1;
                first_vld    <= 1'b0;
                first_pat    <= '0;
                first_key    <= '0;
                first_carry  <= '0;
                second_vld   <= 1'b0;
                second_pat   <= '0;
                second_key   <= '0;
                second_carry <= '0;
              end
            end else begin
              grp_sel <= grp_sel + GRPB'(1);
            end
          end

          PASS2: begin
            if (w_take_second) begin
              r_second_vld   <= 1'b1;
              r_second_pat   <= sort_pat;
              r_second_key   <= w_cand_key;
              r_second_carry <= sort_carry;
            end
            if (w_last) begin
              // Outputs load on entry to DONE so they are valid while done is
              // high; the final group's sample is folded in directly.
              grp_sel      <= '0;
              r_state      <= DONE;
              done         <= 1'b1;
              first_vld    <= r_first_vld;
              first_pat    <= r_first_pat;
              first_key    <= r_first_key;
              first_carry  <= r_first_carry;
              second_vld   <= w_take_second | r_second_vld;
              second_pat   <= w_take_second ? sort_pat   : r_second_pat;
              second_key   <= w_take_second ? w_cand_key : r_second_key;
              second_carry <= w_take_second ? sort_carry : r_second_carry;
            end else begin
              grp_sel <= grp_sel + GRPB'(1);
            end
          end

          DONE: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end

          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_sort_sequencer
// Purpose  : Self-checking bench for pattern_sort_sequencer. A table-driven
//            sorter model answers grp_sel; expected frame results are queued
//            when a frame is launched and a monitor compares them on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_sort_sequencer;

  localparam int NGRP = 7;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [2:0]  grp_sel;
  logic [10:0] sort_pat;
  logic [7:0]  sort_key;
  logic [11:0] sort_carry;
  logic        busy, done, first_vld, second_vld;
  logic [10:0] first_pat, second_pat, first_key, second_key;
  logic [11:0] first_carry, second_carry;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned cyc;
    logic        fv;
    logic [10:0] fp;
    logic [10:0] fk;
    logic [11:0] fc;
    logic        sv;
    logic [10:0] sp;
    logic [10:0] sk;
    logic [11:0] sc;
  } exp_t;

  exp_t exp_q[$];

  // Sorter model tables: index by group, separate answers per pass.
  logic [10:0] p1_pat [8];
  logic [7:0]  p1_key [8];
  logic [11:0] p1_car [8];
  logic [10:0] p2_pat [8];
  logic [7:0]  p2_key [8];
  logic [11:0] p2_car [8];

  int unsigned cyc  = 0;
  int unsigned fcyc = 0;
  logic        launch = 1'b0;
  logic        pass2;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) fcyc <= launch ? 0 : fcyc + 1;
  assign pass2 = (fcyc >= NGRP);

  always_comb begin
    sort_pat   = pass2 ? p2_pat[grp_sel] : p1_pat[grp_sel];
    sort_key   = pass2 ? p2_key[grp_sel] : p1_key[grp_sel];
    sort_carry = pass2 ? p2_car[grp_sel] : p1_car[grp_sel];
  end

  pattern_sort_sequencer #(
    .NGRP(NGRP), .GRPB(3), .PATB(11), .KEYB(8), .CARB(12), .BUSY_SPAN(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .grp_sel(grp_sel), .sort_pat(sort_pat), .sort_key(sort_key),
    .sort_carry(sort_carry), .busy(busy), .done(done),
    .first_vld(first_vld), .second_vld(second_vld),
    .first_pat(first_pat), .second_pat(second_pat),
    .first_key(first_key), .second_key(second_key),
    .first_carry(first_carry), .second_carry(second_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle",   cyc,          e.cyc);
        chk("first_vld",    first_vld,    e.fv);
        chk("first_pat",    first_pat,    e.fp);
        chk("first_key",    first_key,    e.fk);
        chk("first_carry",  first_carry,  e.fc);
        chk("second_vld",   second_vld,   e.sv);
        chk("second_pat",   second_pat,   e.sp);
        chk("second_key",   second_key,   e.sk);
        chk("second_carry", second_carry, e.sc);
      end
    end
  end

  task automatic clear_tabs();
    for (int g = 0; g < 8; g++) begin
      p1_pat[g] = '0; p1_key[g] = '0; p1_car[g] = '0;
      p2_pat[g] = '0; p2_key[g] = '0; p2_car[g] = '0;
    end
  endtask

  task automatic set1(input int g, input logic [10:0] p, input logic [7:0] k,
                      input logic [11:0] c, input bit both);
    p1_pat[g] = p; p1_key[g] = k; p1_car[g] = c;
    if (both) begin
      p2_pat[g] = p; p2_key[g] = k; p2_car[g] = c;
    end
  endtask

  task automatic set2(input int g, input logic [10:0] p, input logic [7:0] k,
                      input logic [11:0] c);
    p2_pat[g] = p; p2_key[g] = k; p2_car[g] = c;
  endtask

  // Drives a start sampled at the next edge (T); returns in the cycle after T.
  task automatic launch_frame(input bit push, input int unsigned lat,
                              input logic fv, input logic [10:0] fp,
                              input logic [10:0] fk, input logic [11:0] fc,
                              input logic sv, input logic [10:0] sp,
                              input logic [10:0] sk, input logic [11:0] sc);
    exp_t e;
    @(posedge clock); #1;
    start  = 1'b1;
    launch = 1'b1;
    if (push) begin
      e.cyc = cyc + lat;
      e.fv = fv; e.fp = fp; e.fk = fk; e.fc = fc;
      e.sv = sv; e.sp = sp; e.sk = sk; e.sc = sc;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    start  = 1'b0;
    launch = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d required=pending0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic tabs_single();
    clear_tabs();
    set1(3, 11'h0A4, 8'h15, 12'hC33, 1'b1);
  endtask

  task automatic tabs_pair();
    clear_tabs();
    set1(2, 11'h080, 8'h10, 12'hA02, 1'b1);
    set1(5, 11'h081, 8'h80, 12'hA05, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    clear_tabs();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",       busy,       0);
    chk("rst_done",       done,       0);
    chk("rst_grp_sel",    grp_sel,    0);
    chk("rst_first_vld",  first_vld,  0);
    chk("rst_second_vld", second_vld, 0);
    chk("rst_first_key",  first_key,  0);
    chk("rst_second_pat", second_pat, 0);
    reset_n = 1'b1;

    // Single valid group; also walk grp_sel through both passes.
    tabs_single();
    launch_frame(1, 15, 1, 11'h0A4, 11'h315, 12'hC33, 0, 0, 0, 0);
    for (int k = 1; k <= 2 * NGRP; k++) begin
      chk("sweep_grp_sel", grp_sel, (k <= NGRP) ? k - 1 : k - 1 - NGRP);
      chk("sweep_busy",    busy,    1);
      @(posedge clock); #1;
    end
    wait_idle();

    // Tie at sk=0x40: lower group wins first, far key becomes second.
    tabs_pair();
    launch_frame(1, 15, 1, 11'h080, 11'h210, 12'hA02, 1, 11'h081, 11'h580, 12'hA05);
    wait_idle();

    // Pass-2 re-hit of the first's key is excluded.
    clear_tabs();
    set1(1, 11'h0C0, 8'h20, 12'hB01, 1'b0);
    set2(1, 11'h0A0, 8'h20, 12'hB11);
    set1(6, 11'h060, 8'h40, 12'hB06, 1'b1);
    launch_frame(1, 15, 1, 11'h0C0, 11'h120, 12'hB01, 1, 11'h060, 11'h640, 12'hB06);
    wait_idle();

    // Window edge: distance 5 eligible, distance 4 (across a group boundary) not.
    clear_tabs();
    set1(0, 11'h0E0, 8'hFC, 12'hD00, 1'b0);
    set2(0, 11'h040, 8'hF7, 12'hD10);
    set2(1, 11'h0C0, 8'h00, 12'hD11);
    launch_frame(1, 15, 1, 11'h0E0, 11'h0FC, 12'hD00, 1, 11'h040, 11'h0F7, 12'hD10);
    wait_idle();

    // No valid candidate (only bend bits set): early done, empty result.
    clear_tabs();
    for (int g = 0; g < NGRP; g++) set1(g, 11'(g % 2), 8'(g * 16), 12'h111, 1'b1);
    launch_frame(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_idle();

    // start during a scan is ignored.
    tabs_single();
    launch_frame(1, 15, 1, 11'h0A4, 11'h315, 12'hC33, 0, 0, 0, 0);
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_idle();

    // abort in pass 2: back to IDLE, no done, previous outputs held.
    tabs_pair();
    launch_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_busy",    busy,    0);
    chk("abort_grp_sel", grp_sel, 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (20) @(posedge clock);
    #1;
    chk("hold_first_vld", first_vld, 1);
    chk("hold_first_key", first_key, 11'h315);
    chk("hold_first_pat", first_pat, 11'h0A4);

    // Asynchronous reset mid-scan, then a clean frame.
    launch_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy",        busy,        0);
    chk("arst_grp_sel",     grp_sel,     0);
    chk("arst_done",        done,        0);
    chk("arst_first_vld",   first_vld,   0);
    chk("arst_first_key",   first_key,   0);
    chk("arst_first_carry", first_carry, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    launch_frame(1, 15, 1, 11'h080, 11'h210, 12'hA02, 1, 11'h081, 11'h580, 12'hA05);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_sort_sequencer.md
# pattern_sort_sequencer

Time-multiplexes one shared best-of-5 pattern sorter across NGRP candidate groups and selects the best and second-best CLCT patterns per frame. On a start pulse it sweeps the group select twice. Pass 1 finds the best pattern. Pass 2 finds the best pattern whose key lies outside a busy window around the first. The block sits between the per-group pattern finders and the CLCT output formatter.

## Interface
- NGRP, 7: number of 5-candidate groups scanned per pass (2..8)
- GRPB, 3: group index width
- PATB, 11: pattern-id width; bit 0 is bend direction and is ignored for sorting
- KEYB, 8: sorter key width (3-bit candidate index + half-strip key)
- CARB, 12: carry (comparator code) width
- BUSY_SPAN, 4: pass-2 exclusion half-width in combined-key units
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame scan; accepted only in IDLE
- abort  in  1  synchronous return to IDLE, no done pulse
- grp_sel  out  GRPB  group currently presented to the shared sorter
- sort_pat  in  PATB  sorter best pattern for grp_sel (combinational, same cycle)
- sort_key  in  KEYB  sorter best key for grp_sel
- sort_carry  in  CARB  sorter best carry for grp_sel
- busy  out  1  high in PASS1/PASS2/DONE
- done  out  1  one-cycle pulse when results are updated
- first_vld, second_vld  out  1  result valid flags
- first_pat, second_pat  out  PATB  selected patterns
- first_key, second_key  out  GRPB+KEYB  combined key {group, sort_key}
- first_carry, second_carry  out  CARB  selected carries

## Operation
- Sort metric: sk = sort_pat[PATB-1:1]. A candidate is valid when sk != 0.
- Replacement: a candidate replaces the running best only when it is valid and its sk is strictly greater. Ties keep the lower group index because groups are scanned in ascending order.
- FSM states: IDLE, PASS1, PASS2, DONE.
  - IDLE: grp_sel=0. On start, clear the running first/second registers and go to PASS1.
  - PASS1: each cycle, sample the sorter output for grp_sel and update the running first; grp_sel increments. When grp_sel==NGRP-1, go to PASS2 with grp_sel=0. If no valid first was found, including the last group's sample, go directly to DONE.
  - PASS2: same sweep. A candidate is eligible only if |{grp_sel,sort_key} - first_key| > BUSY_SPAN, using unsigned distance on GRPB+KEYB bits with no wrap-around. Eligible candidates update the running second. When grp_sel==NGRP-1, go to DONE.
  - DONE: copy running registers to outputs, pulse done, go to IDLE.
- Outputs hold their previous frame's values until the next done.
- start is ignored while busy.
- abort overrides start and all states: go to IDLE, grp_sel=0, outputs unchanged, no done.
- Simultaneous start and abort in IDLE: stay in IDLE.

## Timing
- Reset: state IDLE, grp_sel=0, busy=0, done=0, all result outputs and valids 0.
- start sampled high at edge T: PASS1 occupies cycles T+1..T+NGRP, with grp_sel=0..NGRP-1 in order.
- PASS2 occupies cycles T+NGRP+1..T+2·NGRP.
- done is high during cycle T+2·NGRP+1, and outputs are valid from that cycle.
- No valid first: done is high at T+NGRP+1, with first_vld=second_vld=0.
- Earliest next start is accepted the cycle after done (IDLE). Throughput is 2·NGRP+2 cycles per frame.
- Reset asserted mid-scan: all state and outputs return to reset values immediately.

## Test plan
- NGRP=7, only group 3 returns pat=0x0A4 (sk=0x52), key=0x15 -> done at T+15; first_vld=1, first_key=0x315, first_pat=0x0A4; second_vld=0.
- Groups 2 and 5 both return sk=0x40 with keys far apart (0x10 and 0x80) -> first_key=0x210, second_key=0x580.
- Group 1 returns sk=0x60 at key 0x20; group 1 returns sk=0x50 in pass 2 (distance 0 ≤ BUSY_SPAN); group 6 returns sk=0x30 at key 0x40 -> first_key=0x120, second_key=0x640.
- All sort_pat ≤ 1 (sk=0) -> done at T+8, both valids 0; pat bit 0 differences never alter selection.
- start pulsed again at T+5 -> ignored, done only at T+15; abort at T+9 -> IDLE, no done, previous outputs held.
- reset_n low at T+10 -> busy=0, grp_sel=0, all outputs 0 asynchronously; a fresh start after release completes normally.
